// File: rtl/led_status_pkg.sv
// Shared definitions for the LED status arbiter: FSM state encoding,
// requester count and the one-hot select codes driven into the LED LUT.
package led_status_pkg;

  localparam int NUM_REQ = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SHOW = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam logic [NUM_REQ-1:0] SEL_NONE = 3'b000;
  localparam logic [NUM_REQ-1:0] SEL_REQ0 = 3'b001;
  localparam logic [NUM_REQ-1:0] SEL_REQ1 = 3'b010;
  localparam logic [NUM_REQ-1:0] SEL_REQ2 = 3'b100;

  // Map a requester index to its LUT select code; out-of-range gives blank.
  function automatic logic [NUM_REQ-1:0] sel_of(input logic [1:0] idx);
    logic [NUM_REQ-1:0] sel;
    case (idx)
      2'd0:    sel = SEL_REQ0;
      2'd1:    sel = SEL_REQ1;
      2'd2:    sel = SEL_REQ2;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/led_status_arb_rr_pick3.sv
// rr_pick3: combinational three-way round-robin picker. Searches requesters
// in the order last+1, last+2, last+3 (mod 3) and returns the first one set.
module rr_pick3
  import led_status_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               valid,
  output logic [1:0]         idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  // Successor index modulo 3; an illegal pointer value restarts at 0.
  function automatic logic [1:0] nxt(input logic [1:0] i);
    logic [1:0] n;
    case (i)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Walk the three candidates in rotation order and take the first hit.
  always_comb begin
    cand0  = nxt(last);
    cand1  = nxt(cand0);
    cand2  = nxt(cand1);
    valid  = |req;
    idx    = 2'd0;
    if (req[cand0])      idx = cand0;
    else if (req[cand1]) idx = cand1;
    else if (req[cand2]) idx = cand2;
    onehot = valid ? sel_of(idx) : SEL_NONE;
  end

endmodule

// File: rtl/led_status_arb.sv
// led_status_arb: round-robin scheduler sharing one LED pattern LUT among
// three status requesters. Each grant is shown for a fixed minimum dwell,
// followed by an optional blank gap.
// Optional feature macro: LED_BLINK_EN -- requester 2 blinks during its dwell
// with half-period BLINK_HALF; without it every grant is steady.
module led_status_arb
  import led_status_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000000,
  parameter int GAP_CYCLES   = 5000000,
  parameter int BLINK_HALF   = 12500000,
  parameter int CNT_W        = 26
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic [NUM_REQ-1:0] done
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam int               GAP_M1     = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_M1);
  localparam bit               HAS_GAP    = (GAP_CYCLES > 0);

  // Reject nonsensical configurations at elaboration time.
  if (DWELL_CYCLES < 1 || GAP_CYCLES < 0 || BLINK_HALF < 1) begin : g_bad_param
    $error("led_status_arb: DWELL_CYCLES and BLINK_HALF must be >= 1, GAP_CYCLES >= 0");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [1:0]         last_q,  last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q,  busy_d;
  logic [NUM_REQ-1:0] done_q,  done_d;

  logic               pick_valid;
  logic [1:0]         pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

`ifdef LED_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_off_q, blink_off_d;
`endif

  rr_pick3 u_pick (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Next-state logic: IDLE picks a requester, SHOW times the dwell, GAP
  // times the blank interval. done is a pulse, so it defaults to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    done_d  = SEL_NONE;
`ifdef LED_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
`endif
    case (state_q)
      ST_IDLE: begin
        grant_d = SEL_NONE;
        busy_d  = 1'b0;
        if (pick_valid) begin
          state_d = ST_SHOW;
          grant_d = pick_onehot;
          busy_d  = 1'b1;
          cnt_d   = '0;
          last_d  = pick_idx;
`ifdef LED_BLINK_EN
          blink_cnt_d = '0;
          blink_off_d = 1'b0;
`endif
        end
      end
      ST_SHOW: begin
        // req is deliberately ignored here: the dwell is a guaranteed minimum.
        if (cnt_q == DWELL_LAST) begin
          grant_d = SEL_NONE;
          done_d  = sel_of(last_q);
          cnt_d   = '0;
          if (HAS_GAP) begin
            state_d = ST_GAP;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
`ifdef LED_BLINK_EN
          // Only requester 2 blinks; phase toggles every BLINK_HALF cycles.
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
          end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
          end
          if (last_q == 2'd2 && blink_off_d) grant_d = SEL_NONE;
          else                               grant_d = sel_of(last_q);
`else
          grant_d = sel_of(last_q);
`endif
        end
      end
      ST_GAP: begin
        grant_d = SEL_NONE;
        busy_d  = 1'b1;
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = SEL_NONE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; a reset also drops any pending done pulse.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd2;
      grant_q <= SEL_NONE;
      busy_q  <= 1'b0;
      done_q  <= SEL_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef LED_BLINK_EN
  // Blink phase registers; restarted on every SHOW entry.
  always_ff @(posedge iclk) begin
    if (irst) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end
`endif

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
